nibble_add_seq: RTL and testbench

//  Sequencer that drives one external 4-bit adder slice (a/b/ci -> sum/co) over NIB nibbles to form a
//  4*NIB-bit sum, LSB nibble first. Carry is registered between nibbles.

---
 rtl/nibble_add_seq.sv | 146 ++++++++++++++
 tb/tb_nibble_add_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - sequences one external 4-bit adder slice over NIB nibbles
module nibble_add_seq #(
    parameter int NIB    = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*NIB-1:0]   in_a,
    input  logic [4*NIB-1:0]   in_b,
    input  logic               in_ci,
    output logic [3:0]         add_a,
    output logic [3:0]         add_b,
    output logic               add_ci,
    input  logic [3:0]         add_sum,
    input  logic               add_co,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*NIB-1:0]   out_sum,
    output logic               out_co,
    output logic               busy
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_sum_q, out_sum_d;
    logic            out_co_q, out_co_d;
    logic [3:0]      add_a_q, add_a_d;
    logic [3:0]      add_b_q, add_b_d;
    logic [IW-1:0]   idx_nxt;

    assign idx_nxt = idx_q + 1'b1;

    // Next-state logic; adder operands are registered so they stay stable for the whole settle window
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        out_sum_d = out_sum_q;
        out_co_d  = out_co_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = '0;
                    cnt_d   = '0;
                    carry_d = in_ci;
                    acc_d   = '0;
                    add_a_d = in_a[3:0];
                    add_b_d = in_b[3:0];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d = '0;
                    acc_d[{idx_q, 2'b00} +: 4] = add_sum;
                    if (idx_q == IW'(NIB - 1)) begin
                        // carry is cleared so add_ci reads 0 outside RUN
                        out_sum_d = acc_d;
                        out_co_d  = add_co;
                        carry_d   = 1'b0;
                        add_a_d   = '0;
                        add_b_d   = '0;
                        state_d   = S_DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        carry_d = add_co;
                        add_a_d = a_q[{idx_nxt, 2'b00} +: 4];
                        add_b_d = b_q[{idx_nxt, 2'b00} +: 4];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            acc_q     <= '0;
            out_sum_q <= '0;
            out_co_q  <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            acc_q     <= acc_d;
            out_sum_q <= out_sum_d;
            out_co_q  <= out_co_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_ci    = carry_q;
    assign out_sum   = out_sum_q;
    assign out_co    = out_co_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - directed and random bench for nibble_add_seq with a behavioural adder slice
module tb_nibble_add_seq;

    localparam int NIB  = 4;
    localparam int W    = 4 * NIB;
    localparam int LAT1 = NIB * 1;
    localparam int LAT3 = NIB * 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         in_valid, in_ready, in_ci, add_ci, add_co, out_valid, out_ready, out_co, busy;
    logic [W-1:0] in_a, in_b, out_sum;
    logic [3:0]   add_a, add_b, add_sum;

    logic         in_valid3, in_ready3, in_ci3, add_ci3, add_co3, out_valid3, out_ready3, out_co3, busy3;
    logic [W-1:0] in_a3, in_b3, out_sum3;
    logic [3:0]   add_a3, add_b3, add_sum3;

    nibble_add_seq #(.NIB(NIB), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .busy(busy)
    );

    nibble_add_seq #(.NIB(NIB), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_ci(in_ci3),
        .add_a(add_a3), .add_b(add_b3), .add_ci(add_ci3), .add_sum(add_sum3), .add_co(add_co3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3), .out_co(out_co3), .busy(busy3)
    );

    // Behavioural adder slices
    always_comb {add_co, add_sum}   = {1'b0, add_a}  + {1'b0, add_b}  + {4'b0, add_ci};
    always_comb {add_co3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3} + {4'b0, add_ci3};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Reference model: one operation in flight, result due LAT1 cycles after accept
    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_acc = 0;
    bit spacing_en = 1'b0;
    bit have_prev = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            last_res = '0;
        end else begin
            cyc = cyc + 1;
            if (out_valid && out_ready && exp_q.size() > 0) last_res = exp_q.pop_front();
            if (in_valid && in_ready) begin
                if (spacing_en && have_prev) chk("t6_accept_spacing", cyc - last_acc, LAT1 + 2);
                have_prev = spacing_en;
                last_acc  = cyc;
                acc_cyc   = cyc;
                exp_q.push_back(model_add(in_a, in_b, in_ci));
            end
        end
    end

    // Compare process for the SETTLE=1 instance
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, exp_q.size() == 0);
            chk("busy", busy, exp_q.size() != 0);
            chk("out_valid", out_valid, (exp_q.size() != 0) && (cyc - acc_cyc >= LAT1));
            if (out_valid && exp_q.size() != 0) begin
                chk("out_sum", out_sum, exp_q[0][W-1:0]);
                chk("out_co", out_co, exp_q[0][W]);
            end else if (!out_valid) begin
                chk("out_sum_hold", out_sum, last_res[W-1:0]);
            end
        end
    end

    task automatic accept1(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_add_ci"}, add_ci, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_out_co"}, out_co, 0);
    endtask

    initial begin
        int lat;
        int n;
        logic [3:0]  seq_ci;
        logic [15:0] seq_a;
        logic [47:0] seq_a3;

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; in_ci3 = 1'b0; out_ready3 = 1'b1;
        #1;
        chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        chk("model_pin1", model_add(16'h00AF, 16'h0013, 1'b0), 17'h000C2);
        chk("model_pin2", model_add(16'hFFFF, 16'h0000, 1'b1), 17'h10000);
        chk("model_pin3", model_add(16'h1234, 16'h4321, 1'b0), 17'h05555);

        // 1: basic sum and latency
        accept1(16'h00AF, 16'h0013, 1'b0);
        wait_valid(lat);
        chk("t1_latency", lat, LAT1);
        chk("t1_sum", out_sum, 16'h00C2);
        chk("t1_co", out_co, 0);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk);
        chk("t1_valid_after_hs", out_valid, 0);
        chk("t1_sum_retained", out_sum, 16'h00C2);
        out_ready = 1'b0;

        // 2: full carry ripple
        accept1(16'hFFFF, 16'h0000, 1'b1);
        seq_ci = '0; seq_a = '0;
        for (int i = 0; i < NIB; i++) begin
            if (i > 0) @(negedge clk);
            seq_ci = {seq_ci[2:0], add_ci};
            seq_a  = {seq_a[11:0], add_a};
        end
        chk("t2_add_ci_seq", seq_ci, 4'b1111);
        chk("t2_add_a_seq", seq_a, 16'hFFFF);
        wait_valid(lat);
        chk("t2_sum", out_sum, 16'h0000);
        chk("t2_co", out_co, 1);

        // 3: backpressure in DONE, stray in_valid ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'h5A5A; in_b = 16'h1111; in_ci = 1'b1;
            chk("t3_valid_held", out_valid, 1);
            chk("t3_sum_held", out_sum, 16'h0000);
            chk("t3_co_held", out_co, 1);
            chk("t3_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_after_hs", out_valid, 0);
        @(negedge clk);
        chk("t3_no_queued_op", busy, 0);

        // 4: SETTLE=3 instance
        @(negedge clk);
        in_valid3 = 1'b1; in_a3 = 16'h1234; in_b3 = 16'h4321; in_ci3 = 1'b0;
        chk("t4_ready", in_ready3, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0; in_a3 = 16'hFFFF; in_b3 = 16'hFFFF;
        seq_a3 = '0;
        for (int i = 0; i < LAT3; i++) begin
            if (i > 0) @(negedge clk);
            seq_a3 = {seq_a3[43:0], add_a3};
        end
        chk("t4_add_a_hold", seq_a3, 48'h444333222111);
        chk("t4_not_early", out_valid3, 0);
        @(posedge clk); #1;
        chk("t4_valid_at_12", out_valid3, 1);
        chk("t4_sum", out_sum3, 16'h5555);
        chk("t4_co", out_co3, 0);
        @(negedge clk);

        // 6: back-to-back random operations
        out_ready = 1'b1;
        spacing_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'($urandom_range(0, 1));
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); n++; end
            chk("t6_ready", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        spacing_en = 1'b0;
        repeat (LAT1 + 4) @(negedge clk);

        // 5: abort during nibble 2, then a clean operation
        accept1(16'hA5C3, 16'h0101, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_nib2_a", add_a, 4'h5);
        chk("t5_nib2_b", add_b, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("t5_abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_valid", out_valid, 0);
        end
        accept1(16'hABCD, 16'h1111, 1'b1);
        wait_valid(lat);
        chk("t5_latency", lat, LAT1);
        chk("t5_sum", out_sum, 16'hBCDF);
        chk("t5_co", out_co, 0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
